// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : ex_mem_stage
//  Brief    : EX/MEM pipeline register with valid/ready handshake. A main
//             register drives the outputs; a skid register absorbs one extra
//             bundle so that in_ready comes straight from a flop.
//  Revision : 1.0  initial release
// ============================================================================
module ex_mem_stage #(
  parameter int n = 63
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [n:0] in_result,
  input  logic       in_zero,
  input  logic [n:0] in_store_data,
  input  logic [n:0] in_branch_target,
  input  logic [4:0] in_rd,
  input  logic [4:0] in_ctrl,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [n:0] out_result,
  output logic       out_zero,
  output logic [n:0] out_store_data,
  output logic [n:0] out_branch_target,
  output logic [4:0] out_rd,
  output logic [4:0] out_ctrl,
  output logic       pc_src,
  output logic [1:0] occupancy
);

  // Bundle layout: {result, zero, store_data, branch_target, rd, ctrl}
  localparam int c_BUNDLE_W = 3 * (n + 1) + 11;

  logic                  r_main_valid;
  logic                  r_skid_valid;
  logic [c_BUNDLE_W-1:0] r_main;
  logic [c_BUNDLE_W-1:0] r_skid;
  logic                  r_in_ready;
  logic [1:0]            r_occupancy;

  logic [c_BUNDLE_W-1:0] w_in_bundle;
  logic                  w_in_xfer;
  logic                  w_out_xfer;
  logic                  w_main_valid_nxt;
  logic                  w_skid_valid_nxt;
  logic                  w_main_from_skid;
  logic                  w_main_from_in;
  logic                  w_skid_from_in;

  assign w_in_bundle = {in_result, in_zero, in_store_data, in_branch_target, in_rd, in_ctrl};
  assign w_in_xfer   = in_valid & r_in_ready;
  assign w_out_xfer  = r_main_valid & out_ready;

  // Next-state selection for both slots; flush wins over every other event
  always_comb begin
    w_main_valid_nxt = r_main_valid;
    w_skid_valid_nxt = r_skid_valid;
    w_main_from_skid = 1'b0;
    w_main_from_in   = 1'b0;
    w_skid_from_in   = 1'b0;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (!r_main_valid || w_out_xfer) begin
      if (r_skid_valid) begin
        // Older skid bundle advances first to preserve order
        w_main_from_skid = 1'b1;
        w_main_valid_nxt = 1'b1;
        w_skid_from_in   = w_in_xfer;
        w_skid_valid_nxt = w_in_xfer;
      end else begin
        w_main_from_in   = w_in_xfer;
        w_main_valid_nxt = w_in_xfer;
      end
    end else if (w_in_xfer) begin
      // Main is stalled: park the new bundle in the skid slot
      w_skid_from_in   = 1'b1;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Valid flags plus registered in_ready and occupancy derived from them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_occupancy  <= 2'd0;
    end else begin
      r_main_valid <= w_main_valid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
      r_occupancy  <= {1'b0, w_main_valid_nxt} + {1'b0, w_skid_valid_nxt};
    end
  end

  // Bundle data registers; contents only change when a slot is loaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_main_from_skid) begin
        r_main <= r_skid;
      end else if (w_main_from_in) begin
        r_main <= w_in_bundle;
      end
      if (w_skid_from_in) begin
        r_skid <= w_in_bundle;
      end
    end
  end

  assign {out_result, out_zero, out_store_data, out_branch_target, out_rd, out_ctrl} = r_main;

  assign out_valid = r_main_valid;
  assign in_ready  = r_in_ready;
  assign occupancy = r_occupancy;
  assign pc_src    = r_main_valid & out_ctrl[0] & out_zero;

endmodule
`default_nettype wire

// File: tb/tb_ex_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mem_stage
//  Brief    : Directed and random stimulus for ex_mem_stage, compared against
//             a queue-based reference of held bundles.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ex_mem_stage;

  localparam int N  = 63;
  localparam int BW = 3 * (N + 1) + 11;

  logic         clk;
  logic         reset_n;
  logic         in_valid;
  logic         in_ready;
  logic [N:0]   in_result;
  logic         in_zero;
  logic [N:0]   in_store_data;
  logic [N:0]   in_branch_target;
  logic [4:0]   in_rd;
  logic [4:0]   in_ctrl;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [N:0]   out_result;
  logic         out_zero;
  logic [N:0]   out_store_data;
  logic [N:0]   out_branch_target;
  logic [4:0]   out_rd;
  logic [4:0]   out_ctrl;
  logic         pc_src;
  logic [1:0]   occupancy;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] sb[$];

  ex_mem_stage #(.n(N)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_result        (in_result),
    .in_zero          (in_zero),
    .in_store_data    (in_store_data),
    .in_branch_target (in_branch_target),
    .in_rd            (in_rd),
    .in_ctrl          (in_ctrl),
    .flush            (flush),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_result       (out_result),
    .out_zero         (out_zero),
    .out_store_data   (out_store_data),
    .out_branch_target(out_branch_target),
    .out_rd           (out_rd),
    .out_ctrl         (out_ctrl),
    .pc_src           (pc_src),
    .occupancy        (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] in_bundle();
    return {in_result, in_zero, in_store_data, in_branch_target, in_rd, in_ctrl};
  endfunction

  function automatic logic [BW-1:0] out_bundle();
    return {out_result, out_zero, out_store_data, out_branch_target, out_rd, out_ctrl};
  endfunction

  task automatic drive(input logic v, input logic [N:0] res, input logic z,
                       input logic [N:0] sd, input logic [N:0] bt,
                       input logic [4:0] rd, input logic [4:0] ctrl);
    in_valid         = v;
    in_result        = res;
    in_zero          = z;
    in_store_data    = sd;
    in_branch_target = bt;
    in_rd            = rd;
    in_ctrl          = ctrl;
  endtask

  // Compare outputs to the reference, then advance one clock and update it
  task automatic cyc();
    logic          in_x;
    logic          out_x;
    logic [BW-1:0] front;
    logic          exp_pc;
    int            sz;
    sz = sb.size();
    check("out_valid", 256'(out_valid), 256'(sz > 0));
    check("in_ready",  256'(in_ready),  256'(sz < 2));
    check("occupancy", 256'(occupancy), 256'(sz));
    exp_pc = 1'b0;
    if (sz > 0) begin
      front  = sb[0];
      exp_pc = front[0] & front[BW-N-1-1];
      check("out_bundle", 256'(out_bundle()), 256'(front));
    end
    check("pc_src", 256'(pc_src), 256'(exp_pc));
    in_x  = in_valid && (sz < 2) && !flush;
    out_x = out_ready && (sz > 0);
    @(posedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (out_x) void'(sb.pop_front());
      if (in_x) sb.push_back(in_bundle());
    end
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    #12;
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_in_ready", 256'(in_ready), 256'(1));
    check("rst_occupancy", 256'(occupancy), 256'(0));
    check("rst_pc_src", 256'(pc_src), 256'(0));
    check("rst_out_bundle", 256'(out_bundle()), 256'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Single bundle through an empty stage: one cycle latency
    out_ready = 1'b1;
    drive(1'b1, 64'h5, 1'b0, 64'h55, 64'h0, 5'd3, 5'b10000);
    cyc();
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    check("v1_out_result", 256'(out_result), 256'(64'h5));
    check("v1_occupancy", 256'(occupancy), 256'(1));
    cyc();
    cyc();

    // Two bundles while stalled, then drain in order
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 1'b0, 64'hA1, 64'h10, 5'd1, 5'b10100);
    cyc();
    drive(1'b1, 64'h2, 1'b0, 64'hA2, 64'h20, 5'd2, 5'b11010);
    cyc();
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    check("v2_occupancy", 256'(occupancy), 256'(2));
    check("v2_in_ready", 256'(in_ready), 256'(0));
    check("v2_out_result", 256'(out_result), 256'(64'h1));
    cyc();
    out_ready = 1'b1;
    cyc();
    check("v2_B_result", 256'(out_result), 256'(64'h2));
    check("v2_in_ready_B", 256'(in_ready), 256'(1));
    cyc();
    cyc();

    // Branch: taken when zero and Branch bit set, held while stalled
    out_ready = 1'b0;
    drive(1'b1, 64'h0, 1'b1, 64'h0, 64'h100, 5'd0, 5'b00001);
    cyc();
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    check("v3_pc_src_taken", 256'(pc_src), 256'(1));
    cyc();
    cyc();
    out_ready = 1'b1;
    cyc();
    drive(1'b1, 64'h7, 1'b0, 64'h0, 64'h100, 5'd0, 5'b00001);
    out_ready = 1'b0;
    cyc();
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    check("v3_pc_src_not", 256'(pc_src), 256'(0));
    cyc();
    out_ready = 1'b1;
    cyc();

    // Flush a full stage with a concurrent input
    out_ready = 1'b0;
    drive(1'b1, 64'h11, 1'b0, 64'h1, 64'h2, 5'd4, 5'b10000);
    cyc();
    drive(1'b1, 64'h12, 1'b0, 64'h3, 64'h4, 5'd5, 5'b10000);
    cyc();
    check("v4_full", 256'(occupancy), 256'(2));
    flush = 1'b1;
    drive(1'b1, 64'h13, 1'b0, 64'h5, 64'h6, 5'd6, 5'b10000);
    out_ready = 1'b1;
    cyc();
    flush = 1'b0;
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    check("v4_occupancy", 256'(occupancy), 256'(0));
    check("v4_out_valid", 256'(out_valid), 256'(0));
    check("v4_in_ready", 256'(in_ready), 256'(1));
    cyc();

    // Sustained streaming: one bundle per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 64'(100 + i), 1'(i), 64'(i * 3), 64'(i * 5), 5'(i), 5'(i * 7));
      cyc();
      if (i > 0) check("stream_occ", 256'(occupancy), 256'(1));
    end
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    cyc();
    cyc();

    // Random traffic against the queue reference
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
            {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom), 5'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      flush     = ($urandom_range(0, 63) == 0);
      cyc();
    end
    flush = 1'b0;

    // Asynchronous reset between edges while full
    out_ready = 1'b0;
    drive(1'b1, 64'h21, 1'b1, 64'h1, 64'h1, 5'd1, 5'b00001);
    cyc();
    drive(1'b1, 64'h22, 1'b0, 64'h2, 64'h2, 5'd2, 5'b10000);
    cyc();
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    cyc();
    #1;
    reset_n = 1'b0;
    #1;
    sb.delete();
    check("v6_out_valid", 256'(out_valid), 256'(0));
    check("v6_in_ready", 256'(in_ready), 256'(1));
    check("v6_occupancy", 256'(occupancy), 256'(0));
    check("v6_pc_src", 256'(pc_src), 256'(0));
    check("v6_out_bundle", 256'(out_bundle()), 256'(0));
    #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 64'h33, 1'b0, 64'h9, 64'h8, 5'd7, 5'b10010);
    @(posedge clk); #1;
    sb.push_back({64'h33, 1'b0, 64'h9, 64'h8, 5'd7, 5'b10010});
    drive(1'b0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_mem_stage.md
EX_MEM_STAGE -- requirements
Module: ex_mem_stage

Interface
REQ-001 Parameter: n, default 63, MSB index of all data words (data width n+1).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  upstream ALU stage presents a valid result bundle.
REQ-005 in_ready  output  1  stage can accept a bundle this cycle.
REQ-006 in_result  input  n+1  ALU result.
REQ-007 in_zero  input  1  ALU zero flag (result == 0).
REQ-008 in_store_data  input  n+1  register data for stores (ALU data2 operand).
REQ-009 in_branch_target  input  n+1  precomputed branch target address.
REQ-010 in_rd  input  5  destination register index.
REQ-011 in_ctrl  input  5  {RegWrite, MemRead, MemWrite, MemtoReg, Branch}, MSB first.
REQ-012 flush  input  1  synchronous discard of all held bundles.
REQ-013 out_valid  output  1  held bundle valid toward memory stage.
REQ-014 out_ready  input  1  memory stage accepts the bundle this cycle.
REQ-015 out_result, out_zero, out_store_data, out_branch_target, out_rd, out_ctrl  output  widths as inputs  registered bundle fields.
REQ-016 pc_src  output  1  branch taken indication.
REQ-017 occupancy  output  2  number of bundles held (0..2).

Function
REQ-018 Storage SHALL be a main register (drives out_*) plus one skid register; all bundle fields move together.
REQ-019 Input transfer SHALL occur when in_valid & in_ready at a rising edge; output transfer when out_valid & out_ready.
REQ-020 in_ready SHALL equal NOT skid_valid, driven directly from a flop (no combinational path from out_ready).
REQ-021 Latency: a bundle accepted into an empty stage SHALL appear on out_* with out_valid=1 the following cycle.
REQ-022 Main empty or output transfer this cycle: accepted bundle SHALL load main; if skid held data, skid loads main first and the new bundle loads skid.
REQ-023 Main full, no output transfer, input transfer: bundle SHALL load skid; in_ready drops next cycle.
REQ-024 Skid full and output transfer with no input: skid SHALL move to main; in_ready rises next cycle.
REQ-025 Sustained in_valid=1 and out_ready=1 SHALL give one bundle per cycle, no bubbles, order preserved.
REQ-026 Held out_* fields SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 pc_src SHALL equal out_valid & out_ctrl[0] & out_zero, combinational from main register.
REQ-028 occupancy SHALL equal main_valid + skid_valid, registered.
REQ-029 flush=1 SHALL clear main_valid and skid_valid at the edge, discarding any same-cycle input transfer; flush overrides all other events.
REQ-030 Data fields of invalid entries are don't-care except after reset.

Reset
REQ-031 reset_n=0 SHALL immediately clear main_valid, skid_valid, all out_* data fields to 0, occupancy=0, pc_src=0, in_ready=1.
REQ-032 Reset asserted mid-transfer SHALL drop all bundles; first accept allowed on first edge after reset_n rises.

Verification
V-1 Reset, then in_valid=1, in_result=64'h5, in_ctrl=5'b10000, out_ready=1 for one cycle -> next cycle out_valid=1, out_result=5, occupancy=1, pc_src=0.
V-2 out_ready=0, push bundles A (result=1) and B (result=2) -> occupancy=2, in_ready=0, out_result=1; raise out_ready -> A then B on consecutive cycles, in_ready=1 after B moves to main.
V-3 Bundle with in_zero=1, in_ctrl[0]=1, in_branch_target=64'h100 -> pc_src=1 while held; same bundle with in_zero=0 -> pc_src=0.
V-4 Stage holding 2 bundles, flush=1 with in_valid=1 -> next cycle occupancy=0, out_valid=0, in_ready=1, input discarded.
V-5 Random in_valid/out_ready for 10k cycles vs. FIFO model -> no loss, duplication or reorder; in_ready never 1 while occupancy=2.
V-6 Assert reset_n=0 between edges with occupancy=2 -> out_valid=0 and in_ready=1 before next edge.
